pattern_gen_multi: RTL and testbench
====================================

// Module: pattern_gen_multi
// PURPOSE
//  Parametrised display test-pattern generator; next generation of the fixed gray-level generator.
//  Sits between the sync/timing generator (hcnt/vcnt/de/frame_start) and the output pixel formatter.
//  Adds colour depth scaling, per-frame mode latching, spatial patterns and frame-animated patterns.
//  Output is a 2-cycle pipeline with aligned data-enable.
// PARAMETERS
//  DW        8     bits per colour channel; must be >= 8
//  HW        11    hcnt width
//  VW        12    vcnt width
//  H_ACTIVE  1920  active pixels per line
//  CHK_LOG2  6     checker square size = 2^CHK_LOG2 pixels
//  MOV_W     64    moving-bar width in pixels
//  MOV_STEP  4     moving-bar advance per frame, pixels
//  CYC_FRMS  60    frames per colour step in mode 8
// PORTS
//  clk          in   1     pixel clock
//  rst          in   1     asynchronous reset, active-high
//  mode         in   4     requested pattern; sampled only on frame_start
//  frame_start  in   1     1-cycle pulse at start of frame; issued during blanking
//  de_in        in   1     active-video enable aligned with hcnt/vcnt
//  hcnt         in   HW    horizontal pixel index, 0 at first active pixel
//  vcnt         in   VW    vertical line index, 0 at first active line
//  R, G, B      out  DW    pixel colour, registered
//  de_out       out  1     de_in delayed by 2 cycles
//  mode_active  out  4     currently latched mode
// BEHAVIOUR
//  Reset: R=G=B=0, de_out=0, mode_active=0; bar/move/cycle counters 0; pipeline cleared.
//    Reset mid-frame returns to the same state immediately; the first valid frame follows the next frame_start.
//  Latency: pixel inputs on cycle n -> R/G/B/de_out on cycle n+2. R=G=B=0 whenever de_out=0.
//  Mode latch: mode_active<=mode on the clk edge with frame_start=1.
//    The pixel presented in that same cycle uses the old mode. Mid-frame changes to mode are ignored.
//  Level scale: Lx = x << (DW-8). FS = 2^DW-1.
//  Modes (R=G=B unless stated):
//    0: FS
//    1: L127
//    2: L159
//    3: L95
//    4: 8 vertical colour bars, bar width BW = H_ACTIVE/8 (integer). Order: white, yellow, cyan,
//       green, magenta, red, blue, black; components FS or 0.
//       - Sequential bar counter: reloads to index 0 / offset 0 on de_in rising edge.
//       - Offset increments per active pixel; at BW-1 it clears and the index increments.
//       - Index saturates at 7, so remainder pixels are black.
//    5: horizontal ramp: value = hcnt[DW-1:0], wraps every 2^DW pixels.
//    6: checkerboard: FS if hcnt[CHK_LOG2]^vcnt[CHK_LOG2] is 1, else 0.
//    7: moving bar: FS where pos <= hcnt < pos+MOV_W, else 0.
//       - pos advances by MOV_STEP on each frame_start.
//       - If pos+MOV_STEP >= H_ACTIVE then pos <= 0 (no partial wrap).
//       - The bar is truncated at the right edge; no wrap-around.
//    8: full-field colour cycle FSM: RED -> GREEN -> BLUE -> WHITE -> RED.
//       - The frame counter increments on frame_start while mode_active==8.
//       - At CYC_FRMS-1 it clears and the state advances.
//       - Entering mode 8 from another mode resets the FSM to RED and the counter to 0.
//    9-15: black (0); mode_active still reports the value.
//  Moving-bar pos runs in every mode; only mode 7 displays it.
//  Arithmetic: all comparisons unsigned, at width max(HW, clog2(H_ACTIVE+MOV_W)+1); no overflow permitted.
// TESTING
//  1. rst=1 mid-line with de_in=1 -> R=G=B=0, de_out=0, mode_active=0 on the cycle after assertion.
//  2. mode=2 then frame_start, DW=10 -> active pixels show R=G=B=636; de_out lags de_in by exactly 2.
//  3. mode switched 1->3 mid-frame without frame_start -> output stays 127 until the next frame_start, then 95.
//  4. Mode 4, H_ACTIVE=1920 -> hcnt 0..239 white; 240 gives R=FS, G=FS, B=0; 1680..1919 black; a new line restarts at white.
//  5. Mode 7 over 481 frames -> bar starts at hcnt 0, 4, 8, ...; pos=1916 wraps to 0; the bar at pos 1900 spans only 1900..1919.
//  6. Mode 8, CYC_FRMS=2 -> frames RED, RED, GREEN, GREEN, BLUE, BLUE, WHITE, WHITE, RED; switch to 0 and back restarts at RED.

Source files
------------

// File: rtl/pattern_gen_multi.sv
// Display test-pattern generator: solid levels, colour bars, ramp, checker, moving bar, colour cycle.
// Latency: 2 cycles from hcnt/vcnt/de_in to R/G/B/de_out; mode changes take effect at frame_start.
// Backpressure: none; free-running at pixel rate, every cycle produces an output.
module pattern_gen_multi #(
    parameter int DW       = 8,
    parameter int HW       = 11,
    parameter int VW       = 12,
    parameter int H_ACTIVE = 1920,
    parameter int CHK_LOG2 = 6,
    parameter int MOV_W    = 64,
    parameter int MOV_STEP = 4,
    parameter int CYC_FRMS = 60
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    mode,
    input  logic          frame_start,
    input  logic          de_in,
    input  logic [HW-1:0] hcnt,
    input  logic [VW-1:0] vcnt,
    output logic [DW-1:0] R,
    output logic [DW-1:0] G,
    output logic [DW-1:0] B,
    output logic          de_out,
    output logic [3:0]    mode_active
);

    localparam int BW  = H_ACTIVE / 8;
    localparam int OW  = $clog2(BW + 1);
    localparam int PW0 = $clog2(H_ACTIVE + MOV_W) + 1;
    localparam int AW  = (HW > PW0) ? HW : PW0;
    localparam int CW  = $clog2(CYC_FRMS + 1);
    localparam logic [DW-1:0] FS = {DW{1'b1}};

    typedef enum logic [1:0] {C_RED, C_GREEN, C_BLUE, C_WHITE} cyc_t;

    function automatic logic [DW-1:0] lvl(input logic [7:0] x);
        return DW'(x) << (DW - 8);
    endfunction

    // Only the checker bit of vcnt is used.
    logic unused_vcnt;
    assign unused_vcnt = ^vcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mode_active <= '0;
        else if (frame_start)
            mode_active <= mode;
    end

    // Sequential bar counter, restarted at the first active pixel of each line.
    logic          de_prev;
    logic [2:0]    bar_idx, cur_idx;
    logic [OW-1:0] bar_off, cur_off;
    logic          de_rise;

    assign de_rise = de_in & ~de_prev;
    assign cur_idx = de_rise ? 3'd0 : bar_idx;
    assign cur_off = de_rise ? '0 : bar_off;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_prev <= 1'b0;
            bar_idx <= '0;
            bar_off <= '0;
        end else begin
            de_prev <= de_in;
            if (de_in) begin
                if (cur_off == OW'(BW - 1)) begin
                    bar_off <= '0;
                    bar_idx <= (cur_idx == 3'd7) ? cur_idx : cur_idx + 3'd1;
                end else begin
                    bar_off <= cur_off + OW'(1);
                    bar_idx <= cur_idx;
                end
            end
        end
    end

    // Moving-bar position advances every frame regardless of the displayed mode.
    logic [AW-1:0] pos, hx;
    logic          in_bar;

    assign hx     = AW'(hcnt);
    assign in_bar = (hx >= pos) && (hx < pos + AW'(MOV_W));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pos <= '0;
        else if (frame_start)
            pos <= (pos + AW'(MOV_STEP) >= AW'(H_ACTIVE)) ? '0 : pos + AW'(MOV_STEP);
    end

    // Colour-cycle FSM: held at RED/0 while another mode is latched.
    cyc_t          cyc_q, cyc_d;
    logic [CW-1:0] cyc_cnt, cyc_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q   <= C_RED;
            cyc_cnt <= '0;
        end else begin
            cyc_q   <= cyc_d;
            cyc_cnt <= cyc_cnt_d;
        end
    end

    always_comb begin
        cyc_d     = cyc_q;
        cyc_cnt_d = cyc_cnt;
        if (frame_start) begin
            if (mode_active == 4'd8) begin
                if (cyc_cnt == CW'(CYC_FRMS - 1)) begin
                    cyc_cnt_d = '0;
                    case (cyc_q)
                        C_RED:   cyc_d = C_GREEN;
                        C_GREEN: cyc_d = C_BLUE;
                        C_BLUE:  cyc_d = C_WHITE;
                        default: cyc_d = C_RED;
                    endcase
                end else begin
                    cyc_cnt_d = cyc_cnt + CW'(1);
                end
            end else begin
                cyc_d     = C_RED;
                cyc_cnt_d = '0;
            end
        end
    end

    // Bar order white..black: R off for bars 2,3,6,7; G off for 4..7; B off for odd bars.
    logic [DW-1:0] r_n, g_n, b_n;

    always_comb begin
        r_n = '0;
        g_n = '0;
        b_n = '0;
        case (mode_active)
            4'd0: begin r_n = FS; g_n = FS; b_n = FS; end
            4'd1: begin r_n = lvl(8'd127); g_n = lvl(8'd127); b_n = lvl(8'd127); end
            4'd2: begin r_n = lvl(8'd159); g_n = lvl(8'd159); b_n = lvl(8'd159); end
            4'd3: begin r_n = lvl(8'd95);  g_n = lvl(8'd95);  b_n = lvl(8'd95);  end
            4'd4: begin
                r_n = cur_idx[1] ? '0 : FS;
                g_n = cur_idx[2] ? '0 : FS;
                b_n = cur_idx[0] ? '0 : FS;
            end
            4'd5: begin r_n = DW'(hcnt); g_n = DW'(hcnt); b_n = DW'(hcnt); end
            4'd6: begin
                if (hcnt[CHK_LOG2] ^ vcnt[CHK_LOG2]) begin
                    r_n = FS; g_n = FS; b_n = FS;
                end
            end
            4'd7: begin
                if (in_bar) begin
                    r_n = FS; g_n = FS; b_n = FS;
                end
            end
            4'd8: begin
                case (cyc_q)
                    C_RED:   r_n = FS;
                    C_GREEN: g_n = FS;
                    C_BLUE:  b_n = FS;
                    default: begin r_n = FS; g_n = FS; b_n = FS; end
                endcase
            end
            default: ;
        endcase
    end

    logic          de_d1;
    logic [DW-1:0] r_d1, g_d1, b_d1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_d1  <= 1'b0;
            r_d1   <= '0;
            g_d1   <= '0;
            b_d1   <= '0;
            de_out <= 1'b0;
            R      <= '0;
            G      <= '0;
            B      <= '0;
        end else begin
            de_d1  <= de_in;
            r_d1   <= r_n;
            g_d1   <= g_n;
            b_d1   <= b_n;
            de_out <= de_d1;
            R      <= de_d1 ? r_d1 : '0;
            G      <= de_d1 ? g_d1 : '0;
            B      <= de_d1 ? b_d1 : '0;
        end
    end

endmodule

// File: tb/tb_pattern_gen_multi.sv
// Randomised and directed bench for pattern_gen_multi (DW=10, CYC_FRMS=2).
// Expected pixels are queued at stimulus time and consumed by an output monitor.
module tb_pattern_gen_multi;

    localparam int DW = 10;
    localparam int HW = 11;
    localparam int VW = 12;
    localparam int FS = 1023;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    mode = '0;
    logic          frame_start = 1'b0;
    logic          de_in = 1'b0;
    logic [HW-1:0] hcnt = '0;
    logic [VW-1:0] vcnt = '0;
    logic [DW-1:0] R, G, B;
    logic          de_out;
    logic [3:0]    mode_active;

    pattern_gen_multi #(.DW(DW), .HW(HW), .VW(VW), .CYC_FRMS(2)) dut (
        .clk(clk), .rst(rst), .mode(mode), .frame_start(frame_start),
        .de_in(de_in), .hcnt(hcnt), .vcnt(vcnt),
        .R(R), .G(G), .B(B), .de_out(de_out), .mode_active(mode_active)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [3*DW-1:0] exp_q[$];
    logic [1:0] hist = 2'b00;

    // Reference state: latched mode, frame_starts since reset, frames spent in mode 8.
    int mode_m = 0;
    int nfs    = 0;
    int m8     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3*DW-1:0] pix(input int r, input int g, input int b);
        return {DW'(r), DW'(g), DW'(b)};
    endfunction

    function automatic logic [3*DW-1:0] expc(input int md, input int k, input int v);
        int idx, p;
        case (md)
            0: return pix(FS, FS, FS);
            1: return pix(127 * 4, 127 * 4, 127 * 4);
            2: return pix(636, 636, 636);
            3: return pix(95 * 4, 95 * 4, 95 * 4);
            4: begin
                idx = (k / 240 > 7) ? 7 : k / 240;
                case (idx)
                    0: return pix(FS, FS, FS);
                    1: return pix(FS, FS, 0);
                    2: return pix(0, FS, FS);
                    3: return pix(0, FS, 0);
                    4: return pix(FS, 0, FS);
                    5: return pix(FS, 0, 0);
                    6: return pix(0, 0, FS);
                    default: return pix(0, 0, 0);
                endcase
            end
            5: return pix(k % 1024, k % 1024, k % 1024);
            6: return (((k / 64) + (v / 64)) % 2 == 1) ? pix(FS, FS, FS) : pix(0, 0, 0);
            7: begin
                p = 4 * (nfs % 480);
                return (k >= p && k < p + 64) ? pix(FS, FS, FS) : pix(0, 0, 0);
            end
            8: begin
                case ((m8 / 2) % 4)
                    0: return pix(FS, 0, 0);
                    1: return pix(0, FS, 0);
                    2: return pix(0, 0, FS);
                    default: return pix(FS, FS, FS);
                endcase
            end
            default: return pix(0, 0, 0);
        endcase
    endfunction

    task automatic step(input logic fs, input logic de, input int h, input int v);
        @(posedge clk);
        #1;
        frame_start = fs;
        de_in       = de;
        hcnt        = HW'(h);
        vcnt        = VW'(v);
    endtask

    task automatic frame(input int md);
        step(1'b1, 1'b0, 0, 0);
        mode = 4'(md);
        if (mode_m == 8) m8++;
        else m8 = 0;
        nfs++;
        mode_m = md;
        step(1'b0, 1'b0, 0, 0);
        @(negedge clk);
        chk("mode_active", 32'(mode_active), 32'(mode_m));
    endtask

    task automatic line(input int len, input int v);
        for (int k = 0; k < len; k++) begin
            step(1'b0, 1'b1, k, v);
            exp_q.push_back(expc(mode_m, k, v));
        end
        repeat (3) step(1'b0, 1'b0, 0, 0);
    endtask

    // Output monitor: de_out must equal de_in from two cycles earlier.
    always @(negedge clk) begin
        if (rst) begin
            hist = 2'b00;
        end else begin
            chk("de_lag", 32'(de_out), 32'(hist[1]));
            if (de_out) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pixel: got 0x%0h with empty queue, want no pixel at %0t", {R, G, B}, $time);
                end else begin
                    chk("pixel", 32'({R, G, B}), 32'(exp_q.pop_front()));
                end
            end else begin
                chk("blank_zero", 32'({R, G, B}), 32'd0);
            end
            hist = {hist[0], de_in};
        end
    end

    initial begin
        int p;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rgb", 32'({R, G, B}), 32'd0);
        chk("rst_de", 32'(de_out), 32'd0);
        chk("rst_mode", 32'(mode_active), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Fixed levels and mid-frame mode change
        frame(2); line(40, 0); line(40, 1);
        frame(1); line(30, 2);
        mode = 4'd3;
        line(30, 3);
        frame(3); line(30, 4);
        frame(0); line(20, 5);

        // Colour bars, ramp, checkerboard
        frame(4); line(1920, 0); line(300, 1);
        frame(5); line(1500, 0);
        frame(6); line(200, 0); line(200, 64); line(200, 100);

        // Moving bar over a full position cycle
        for (int f = 0; f < 481; f++) begin
            frame(7);
            p = 4 * (nfs % 480);
            if (p <= 8 || p == 960 || p == 1900 || p == 1916)
                line(1920, 10);
        end

        // Colour cycle, then leave and re-enter
        for (int f = 0; f < 9; f++) begin
            frame(8); line(16, f);
        end
        frame(0); line(16, 0);
        frame(8); line(16, 0);

        // Random modes, lengths and ignored mid-frame mode requests
        for (int f = 0; f < 30; f++) begin
            frame($urandom_range(0, 15));
            for (int l = 0; l < int'($urandom_range(1, 2)); l++) begin
                mode = 4'($urandom_range(0, 15));
                line($urandom_range(1, 300), $urandom_range(0, 4095));
            end
        end

        // Reset in the middle of an active line
        frame(5);
        for (int k = 0; k < 50; k++) begin
            step(1'b0, 1'b1, k, 0);
            exp_q.push_back(expc(mode_m, k, 0));
        end
        @(posedge clk);
        #3 rst = 1'b1;
        @(negedge clk);
        chk("midrst_rgb", 32'({R, G, B}), 32'd0);
        chk("midrst_de", 32'(de_out), 32'd0);
        chk("midrst_mode", 32'(mode_active), 32'd0);
        de_in = 1'b0;
        mode  = 4'd0;
        exp_q.delete();
        mode_m = 0; nfs = 0; m8 = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step(1'b0, 1'b0, 0, 0);
        @(negedge clk);
        chk("post_rst_mode", 32'(mode_active), 32'd0);
        frame(7); line(200, 0);
        frame(4); line(500, 0);

        repeat (4) step(1'b0, 1'b0, 0, 0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
